// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the RAM arbiter
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_DR,
        GNT_DW,
        ABORT
    } arb_state_t;

    localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

    function automatic logic is_grant(arb_state_t s);
        return (s == GNT_I) || (s == GNT_DR) || (s == GNT_DW);
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - counts stalled grant cycles and flags the last allowed one
module arb_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire marks the cycle holding count TIMEOUT-1, so the abort follows TIMEOUT stalled cycles
    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and data requesters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int    TIMEOUT      = 64,
    parameter int    MAX_D_STREAK = 4,
    parameter word_t ERR_WORD     = ARB_ERR_WORD
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  iREN,
    input  word_t iaddr,
    output word_t iload,
    output logic  iwait,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output word_t dload,
    output logic  dwait,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload,
    input  logic  ram_ready,
    output logic  err
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          abort_is_data_q;
    logic          abort_is_data_d;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    logic d_req;
    logic owner_req;
    logic done;
    logic i_done;
    logic d_done;
    logic abort_i;
    logic abort_d;
    logic tmo_en;
    logic tmo_expire;

    assign d_req = dREN | dWEN;

    // The owner's own strobe keeps the grant alive; dropping it abandons the access
    always_comb begin
        owner_req = 1'b0;
        case (state_q)
            GNT_I:   owner_req = iREN;
            GNT_DR:  owner_req = dREN;
            GNT_DW:  owner_req = dWEN;
            default: owner_req = 1'b0;
        endcase
    end

    assign done    = is_grant(state_q) && owner_req && ram_ready;
    assign i_done  = done && (state_q == GNT_I);
    assign d_done  = done && (state_q != GNT_I);
    assign abort_i = (state_q == ABORT) && !abort_is_data_q;
    assign abort_d = (state_q == ABORT) && abort_is_data_q;
    assign tmo_en  = owner_req && !ram_ready;

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .clr_i    (!tmo_en),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d         = state_q;
        abort_is_data_d = abort_is_data_q;
        case (state_q)
            IDLE: begin
                if (d_req && (streak_q < STREAK_MAX)) begin
                    state_d = dWEN ? GNT_DW : GNT_DR;
                end else if (iREN) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_DR, GNT_DW: begin
                if (!owner_req || ram_ready) begin
                    state_d = IDLE;
                end else if (tmo_expire) begin
                    state_d         = ABORT;
                    abort_is_data_d = (state_q != GNT_I);
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Data wins arbitration only until it has completed MAX_D_STREAK accesses over a waiting fetch
    always_comb begin
        streak_d = streak_q;
        if (!iREN) begin
            streak_d = '0;
        end else if ((state_q == IDLE) && (state_d == GNT_I)) begin
            streak_d = '0;
        end else if (d_done && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q         <= IDLE;
            abort_is_data_q <= 1'b0;
            streak_q        <= '0;
        end else begin
            state_q         <= state_d;
            abort_is_data_q <= abort_is_data_d;
            streak_q        <= streak_d;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            GNT_I: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            GNT_DR: begin
                ramREN  = 1'b1;
                ramaddr = daddr;
            end
            GNT_DW: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    always_comb begin
        iload = '0;
        dload = '0;
        if (i_done) begin
            iload = ramload;
        end else if (abort_i) begin
            iload = ERR_WORD;
        end
        if (d_done && (state_q == GNT_DR)) begin
            dload = ramload;
        end else if (abort_d) begin
            dload = ERR_WORD;
        end
    end

    assign iwait = iREN && !(i_done || abort_i);
    assign dwait = d_req && !(d_done || abort_d);
    assign err   = (state_q == ABORT);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int          TIMEOUT      = 64;
    localparam int          MAX_D_STREAK = 4;
    localparam logic [31:0] ERR_WORD     = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        err;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .TIMEOUT      (TIMEOUT),
        .MAX_D_STREAK (MAX_D_STREAK),
        .ERR_WORD     (ERR_WORD)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready),
        .err       (err)
    );

    int checks   = 0;
    int failures = 0;

    // Model: which requester holds the RAM, for how long, and how many data wins in a row
    bit m_busy   = 0;
    bit m_isd    = 0;
    bit m_wr     = 0;
    bit m_abort  = 0;
    int m_age    = 0;
    int m_streak = 0;

    logic        e_iwait;
    logic        e_dwait;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic        oreq;
        logic        fin;
        logic        mine_i;
        logic        mine_d;
        logic [31:0] e_addr;
        logic [31:0] e_il;
        logic [31:0] e_dl;
        @(negedge CLK);
        oreq   = m_isd ? (m_wr ? dWEN : dREN) : iREN;
        fin    = m_busy && oreq && ram_ready;
        mine_i = (fin || m_abort) && !m_isd;
        mine_d = (fin || m_abort) && m_isd;
        e_addr = !m_busy ? 32'h0 : (m_isd ? daddr : iaddr);
        e_il   = !mine_i ? 32'h0 : (m_abort ? ERR_WORD : ramload);
        e_dl   = !mine_d ? 32'h0 : (m_abort ? ERR_WORD : (m_wr ? 32'h0 : ramload));
        e_iwait = iREN && !mine_i;
        e_dwait = (dREN || dWEN) && !mine_d;
        chk1 ("ramREN",   ramREN,   m_busy && !m_wr);
        chk1 ("ramWEN",   ramWEN,   m_busy && m_wr);
        chk32("ramaddr",  ramaddr,  e_addr);
        chk32("ramstore", ramstore, (m_busy && m_wr) ? dstore : 32'h0);
        chk32("iload",    iload,    e_il);
        chk32("dload",    dload,    e_dl);
        chk1 ("iwait",    iwait,    e_iwait);
        chk1 ("dwait",    dwait,    e_dwait);
        chk1 ("err",      err,      m_abort);
    endtask

    task automatic advance();
        bit oreq;
        int old_streak;
        @(posedge CLK);
        oreq       = m_isd ? (m_wr ? dWEN : dREN) : iREN;
        old_streak = m_streak;
        if (!nRST) begin
            m_busy = 0; m_abort = 0; m_isd = 0; m_wr = 0; m_age = 0; m_streak = 0;
        end else begin
            if (!iREN) m_streak = 0;
            else if (m_busy && m_isd && oreq && ram_ready && m_streak < MAX_D_STREAK) m_streak++;
            if (m_abort) begin
                m_abort = 0;
            end else if (m_busy) begin
                if (!oreq || ram_ready) begin
                    m_busy = 0; m_age = 0;
                end else if (m_age == TIMEOUT - 1) begin
                    m_busy = 0; m_abort = 1; m_age = 0;
                end else begin
                    m_age++;
                end
            end else if ((dREN || dWEN) && old_streak < MAX_D_STREAK) begin
                m_busy = 1; m_isd = 1; m_wr = dWEN; m_age = 0;
            end else if (iREN) begin
                m_busy = 1; m_isd = 0; m_wr = 0; m_age = 0; m_streak = 0;
            end
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        byte  grants[$];
        int   err_k;
        int   err_cnt;
        logic [31:0] err_load;
        logic err_dwait;
        bit   i_fin;
        bit   d_fin;
        int   kind;

        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h0; dREN = 1'b1; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ram_ready = 1'b0;

        // Reset with requests pending
        advance();
        sample();
        chk1("rst_iwait", iwait, 1'b1);
        chk1("rst_dwait", dwait, 1'b1);
        chk1("rst_ramREN", ramREN, 1'b0);
        chk1("rst_err", err, 1'b0);
        advance();
        iREN = 1'b0; dREN = 1'b0; nRST = 1'b1;
        tick();

        // Single instruction fetch
        iREN = 1'b1; iaddr = 32'h100; ramload = 32'h8C220004; ram_ready = 1'b1;
        sample();
        chk1("if_c0_ramREN", ramREN, 1'b0);
        advance();
        sample();
        chk1("if_c1_ramREN", ramREN, 1'b1);
        chk32("if_c1_ramaddr", ramaddr, 32'h100);
        chk1("if_c1_iwait", iwait, 1'b0);
        chk32("if_c1_iload", iload, 32'h8C220004);
        advance();
        iREN = 1'b0;
        sample();
        chk1("if_c2_ramREN", ramREN, 1'b0);
        advance();

        // Simultaneous write and fetch: data first
        iREN = 1'b1; iaddr = 32'h104; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        tick();
        sample();
        chk1("sim_dw_ramWEN", ramWEN, 1'b1);
        chk32("sim_dw_ramstore", ramstore, 32'hDEADBEEF);
        chk1("sim_dw_iwait", iwait, 1'b1);
        advance();
        dWEN = 1'b0;
        sample();
        chk1("sim_idle_iwait", iwait, 1'b1);
        advance();
        sample();
        chk1("sim_i_ramREN", ramREN, 1'b1);
        chk32("sim_i_ramaddr", ramaddr, 32'h104);
        chk1("sim_i_iwait", iwait, 1'b0);
        advance();
        iREN = 1'b0;
        tick();

        // Starvation guard
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h380; ramload = 32'h1234;
        for (int c = 0; c < 14; c++) begin
            sample();
            if (ramREN === 1'b1 && ramaddr === 32'h300) grants.push_back("I");
            else if (ramREN === 1'b1 && ramaddr === 32'h380) grants.push_back("D");
            advance();
        end
        chk32("starve_ngrants_ge6", 32'(grants.size() >= 6), 32'd1);
        for (int g = 0; g < 6; g++) begin
            byte want;
            want = (g == 4) ? "I" : "D";
            chk32($sformatf("starve_grant%0d", g), 32'((g < grants.size()) ? grants[g] : 8'h0), 32'(want));
        end
        iREN = 1'b0; dREN = 1'b0;
        tick();
        tick();

        // Timeout abort
        dREN = 1'b1; daddr = 32'h400; ram_ready = 1'b0;
        err_k = -1; err_cnt = 0; err_load = 32'h0; err_dwait = 1'b1;
        tick();
        for (int k = 0; k < 70; k++) begin
            sample();
            if (err === 1'b1) begin
                err_cnt++;
                err_k     = k;
                err_load  = dload;
                err_dwait = dwait;
                dREN      = 1'b0;
            end
            advance();
        end
        chk32("tmo_err_cycle", 32'(err_k), 32'd64);
        chk32("tmo_err_count", 32'(err_cnt), 32'd1);
        chk32("tmo_dload", err_load, 32'hBAD1BAD1);
        chk1("tmo_dwait", err_dwait, 1'b0);
        dREN = 1'b0;

        // Data request withdrawn mid-grant
        dREN = 1'b1; daddr = 32'h500;
        tick();
        sample();
        chk1("wd_gnt_ramREN", ramREN, 1'b1);
        advance();
        dREN = 1'b0;
        tick();
        sample();
        chk1("wd_idle_ramREN", ramREN, 1'b0);
        chk1("wd_err", err, 1'b0);
        advance();

        // Reset during an instruction grant
        iREN = 1'b1; iaddr = 32'h600; ram_ready = 1'b0;
        tick();
        sample();
        chk1("rm_gnt_ramREN", ramREN, 1'b1);
        nRST = 1'b0;
        advance();
        nRST = 1'b1;
        sample();
        chk1("rm_idle_ramREN", ramREN, 1'b0);
        chk1("rm_idle_ramWEN", ramWEN, 1'b0);
        chk1("rm_idle_err", err, 1'b0);
        advance();
        ram_ready = 1'b1; ramload = 32'hCAFE0001;
        sample();
        chk1("rm_regrant_ramREN", ramREN, 1'b1);
        chk32("rm_regrant_ramaddr", ramaddr, 32'h600);
        advance();
        iREN = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ram_ready = ($urandom_range(0, 3) != 0);
            ramload   = $urandom;
            nRST      = ($urandom_range(0, 299) != 0);
            sample();
            i_fin = iREN && !e_iwait;
            d_fin = (dREN || dWEN) && !e_dwait;
            advance();
            if (iREN) begin
                if (i_fin || $urandom_range(0, 39) == 0) iREN = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                iREN  = 1'b1;
                iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (dREN || dWEN) begin
                if (d_fin || $urandom_range(0, 39) == 0) begin
                    dREN = 1'b0; dWEN = 1'b0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                kind   = $urandom_range(0, 3);
                dWEN   = (kind <= 1);
                dREN   = (kind != 0);
                daddr  = $urandom & 32'hFFFF_FFFC;
                dstore = $urandom;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch requester and the data requester of the datapath.
- Sits between the cache-side request signals (imemREN/imemaddr, dmemREN/dmemWEN/dmemaddr/dmemstore) and the RAM.
- Sequences one RAM transaction at a time with a grant FSM, gives data priority with a starvation guard, and aborts hung accesses with a timeout counter.

Parameters:
- TIMEOUT, 64, max cycles a granted access waits for ram_ready before abort.
- MAX_D_STREAK, 4, max consecutive data grants while an instruction request is pending.
- ERR_WORD, 32'hBAD1BAD1, load value returned on timeout abort.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on the CLK rising edge.
- iREN  in  1  instruction read request; held until iwait deasserts.
- iaddr  in  32  instruction address; stable while iREN is high.
- iload  out  32  instruction read data; valid when iREN and !iwait.
- iwait  out  1  instruction stall.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins if dREN is also high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dload  out  32  data read data.
- dwait  out  1  data stall.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ram_ready  in  1  RAM completes the strobed access in this cycle.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset:
  - state=IDLE, tcnt=0, streak=0.
  - All RAM strobes 0, ramaddr/ramstore 0, iload/dload 0, err 0.
  - iwait = iREN and dwait = dREN (pending requests see a stall).
- States:
  - IDLE: no RAM strobes.
  - GNT_I: ramREN=1, ramaddr=iaddr.
  - GNT_DR: ramREN=1, ramaddr=daddr.
  - GNT_DW: ramWEN=1, ramaddr=daddr, ramstore=dstore.
  - ABORT: one cycle, err=1.
- IDLE arbitration, registered grant (no RAM strobe in the IDLE cycle):
  - Data request pending and streak<MAX_D_STREAK: grant data (DW if dWEN, else DR).
  - Otherwise: grant I if iREN.
  - Otherwise: stay IDLE.
- Grant states:
  - ram_ready=1: requester's wait=0 this cycle. Load output = ramload for reads; dload=0 on writes. Next state IDLE, tcnt=0.
  - ram_ready=0: tcnt+1.
  - tcnt==TIMEOUT-1 with no ready: next ABORT.
- ABORT cycle:
  - Owning requester's wait=0 and its load = ERR_WORD.
  - RAM strobes 0; next IDLE.
- Latency: minimum 2 cycles per access (1 arbitration + 1 RAM cycle). The two requests are never serviced in the same cycle.
- Streak counter:
  - Increments on each completed data access while iREN=1.
  - Clears on any instruction grant or when iREN=0.
  - Saturates at MAX_D_STREAK.
- Wait outputs: a non-owner with a pending request sees wait=1. A requester with no request sees wait=0.
- Request dropped mid-grant (owner's REN/WEN falls): next state IDLE, no completion signalled, tcnt cleared, no err.
- dWEN and dREN both high: treated as write (GNT_DW).
- The block does not latch addresses; requesters hold addr/data stable until wait falls.
- nRST low during any state: next edge forces reset values. An in-flight access is abandoned and no err is raised.

Decomposition:
- Shared package (the project's types package): arb_state_t enum {IDLE, GNT_I, GNT_DR, GNT_DW, ABORT}, the ERR_WORD constant, and the word_t type.
- One natural sub-module, arb_timeout_ctr: clear/enable inputs, expire output, TIMEOUT parameter. The FSM and output muxing stay in mem_arbiter.

Test Plan:
- Single I fetch: iREN=1, iaddr=0x100, ram_ready high one cycle after grant with ramload=0x8C220004 -> ramREN and ramaddr=0x100 in cycle 1, iwait=0 and iload=0x8C220004 in cycle 1, IDLE in cycle 2.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x200, dstore=0xDEADBEEF) in the same cycle, ram_ready always 1 -> GNT_DW first with ramstore=0xDEADBEEF, then GNT_I; iwait stays 1 until the I grant completes.
- Starvation guard: iREN held, dREN re-asserted continuously, MAX_D_STREAK=4 -> exactly 4 data grants, then one GNT_I, then data resumes.
- Timeout: dREN=1, ram_ready held 0, TIMEOUT=64 -> err=1 for exactly one cycle 64 cycles after the grant, dwait=0 with dload=0xBAD1BAD1 that same cycle, then IDLE.
- Request withdrawn: GNT_DR active, ram_ready=0, dREN dropped -> next cycle IDLE, ramREN=0, err never asserted.
- Reset mid-access: nRST=0 for one edge during GNT_I -> next cycle IDLE with all RAM strobes 0 and tcnt=0. The pending iREN is re-granted 1 cycle after nRST returns high.
